// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-enable bases, funct3 codes.
// Pure declarations; no timing or flow-control content.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Illegal size or a half/word not naturally aligned within its word.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_X) || ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and lane-replicated data, load shift-down and size mask.
// Purely combinational, zero latency, no flow control.
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = ld_word >> {off, 3'b000};
    be       = BE_W;
    st_lanes = st_data;
    ld_data  = shifted;
    case (size)
      SZ_B: begin
        be       = BE_B << off;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {24'h0, shifted[7:0]};
      end
      SZ_H: begin
        be       = BE_H << off;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage: IDLE -> BUS (until mem_ack or timeout) -> RESP one-cycle pulse; best case 2 cycles, error 1.
// req_ready only in IDLE; mem_* held stable while waiting on mem_ack.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [2:0]        rsp_funct3,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        in_bus;
  logic        in_resp;

  lsu_lane_align u_align (
    .size     (funct3_q[1:0]),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (mem_rdata),
    .be       (lane_be),
    .st_lanes (lane_wdata),
    .ld_data  (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          cnt_d    = '0;
          if (access_bad(req_funct3[1:0], req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (mem_ack) begin
          rdata_d = write_q ? 32'h0 : lane_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode straight off the state register so reset clears them immediately.
  assign in_bus     = (state_q == ST_BUS);
  assign in_resp    = (state_q == ST_RESP);
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = in_bus;
  assign mem_we     = in_bus & write_q;
  assign mem_addr   = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be     = in_bus ? lane_be : 4'h0;
  assign mem_wdata  = in_bus ? lane_wdata : 32'h0;
  assign rsp_valid  = in_resp;
  assign rsp_rdata  = in_resp ? rdata_q : 32'h0;
  assign rsp_funct3 = in_resp ? funct3_q : 3'h0;
  assign rsp_err    = in_resp & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model and transaction-level expectations.
module tb_load_store_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [2:0]        rsp_funct3;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_funct3 (rsp_funct3),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bus-side memory: commits whatever the DUT presents on an acked write.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) bus_mem[{mem_addr[7:2], 2'(i)}] = mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      bus_mem[{a[7:2], 2'(i)}] = v[8*i +: 8];
      ref_mem[{a[7:2], 2'(i)}] = v[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] bus_word(input logic [7:0] a);
    return {bus_mem[{a[7:2], 2'd3}], bus_mem[{a[7:2], 2'd2}],
            bus_mem[{a[7:2], 2'd1}], bus_mem[{a[7:2], 2'd0}]};
  endfunction

  // One full transaction; called at a negedge with the DUT idle, returns at a negedge with it idle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int delay);
    int          n;
    logic        bad;
    logic        acked;
    logic        exp_err;
    logic [7:0]  a;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    n       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad     = (f3[1:0] == 2'd3) || ((addr % n) != 0);
    a       = addr[7:0];
    exp_be  = 4'(((1 << n) - 1) << (addr % 4));
    exp_wd  = '0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    exp_rd  = '0;
    for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[a + 8'(i)];
    acked   = 1'b0;

    check("idle_ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    mem_ack    = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    req_wdata  = $urandom;
    mem_ack    = 1'b0;

    if (!bad) begin
      for (int k = 0; k < TIMEOUT && !acked; k++) begin
        check("bus_req", {31'h0, mem_req}, 32'h1);
        check("bus_addr", mem_addr, {addr[31:2], 2'b00});
        check("bus_be", {28'h0, mem_be}, {28'h0, exp_be});
        check("bus_we", {31'h0, mem_we}, {31'h0, wr});
        if (wr) check("bus_wdata", mem_wdata, exp_wd);
        check("bus_no_rsp", {31'h0, rsp_valid}, 32'h0);
        if (k == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_word(a);
          acked     = 1'b1;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end

    exp_err = bad || !acked;
    check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    check("rsp_rdata", rsp_rdata, (wr || exp_err) ? 32'h0 : exp_rd);
    check("rsp_funct3", {29'h0, rsp_funct3}, {29'h0, f3});
    check("rsp_no_req", {31'h0, mem_req}, 32'h0);
    if (wr && !exp_err) begin
      for (int i = 0; i < n; i++) ref_mem[a + 8'(i)] = wd[8*i +: 8];
    end
    check("mem_word", bus_word(a), {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
                                    ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]});
    if (!bad && !acked) mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
    check("back_ready", {31'h0, req_ready}, 32'h1);
    check("idle_no_req", {31'h0, mem_req}, 32'h0);
    if (!bad && !acked) begin
      @(posedge clk);
      @(negedge clk);
      check("late_ack_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check("late_ack_no_req", {31'h0, mem_req}, 32'h0);
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [2:0]  f3;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_outs", mem_addr | mem_wdata | rsp_rdata | {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 2);
    set_word(8'h00, 32'h80112233);
    do_req(1'b0, 32'h103, 3'b000, 32'h0, 0);
    do_req(1'b1, 32'h102, 3'b001, 32'h1234ABCD, 1);
    set_word(8'h00, 32'hBEEF0000);
    do_req(1'b0, 32'h102, 3'b101, 32'h0, 0);
    do_req(1'b0, 32'h102, 3'b010, 32'h0, 0);
    do_req(1'b1, 32'h101, 3'b001, 32'h55AA55AA, 0);
    do_req(1'b0, 32'h100, 3'b011, 32'h0, 0);
    do_req(1'b0, 32'h0,   3'b010, 32'h0, 99);
    do_req(1'b0, 32'h10,  3'b010, 32'h0, TIMEOUT - 1);

    // Reset in the middle of a bus wait abandons the access silently.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midbus_rst_req", {31'h0, mem_req}, 32'h0);
    check("midbus_rst_ready", {31'h0, req_ready}, 32'h1);
    check("midbus_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    set_word(8'h00, 32'h0000FF00);
    do_req(1'b0, 32'h1, 3'b100, 32'h0, 0);

    for (int t = 0; t < 200; t++) begin
      addr = {$urandom_range(0, 15) == 0 ? 24'($urandom) : 24'h0, 8'($urandom)};
      if ($urandom_range(0, 3) != 0) addr[1:0] = (t % 2 == 0) ? 2'b00 : addr[1:0] & 2'b10;
      f3 = 3'($urandom);
      do_req(1'($urandom), addr, f3, $urandom, $urandom_range(0, TIMEOUT + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage between execute and the memory sign-extension stage.
- Accepts one load/store request at a time and drives a word-aligned data-memory bus with byte enables, waiting on a memory acknowledge.
- For loads, returns read data shifted down to bit 0 and zero-filled above the access size, which the sign extender consumes directly.
- Flags misaligned and illegal-size accesses, and bus timeouts, without corrupting memory.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles in BUS without mem_ack before aborting with error; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  unit idle, can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_funct3  in  3  RISC-V funct3; [1:0] gives size: 00 byte, 01 half, 10 word, 11 illegal
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load data, right-aligned, zero above size (feeds RawMem)
- rsp_funct3  out  3  funct3 of the completed access (feeds the extender)
- rsp_err  out  1  misaligned, illegal size or timeout; valid with rsp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address, [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus acknowledge; rdata valid in the same cycle
- mem_rdata  in  32  bus read word

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all outputs 0 except req_ready = 1; timeout counter = 0.
  - mem_req drops immediately, even mid-BUS; an in-flight access is abandoned and no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, addr, funct3 and wdata; off = addr[1:0].
  - Error check: size 11, half with off[0] = 1, or word with off != 0 -> go to RESP with err = 1. No bus cycle is issued.
  - Otherwise -> BUS.
- BUS:
  - mem_req = 1; mem_addr = {addr[ADDR_W-1:2], 2'b00}; mem_we = write.
  - mem_be: byte 0001 << off; half 0011 << off; word 1111. Loads drive the same be.
  - mem_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - All mem_* outputs are held stable until ack.
  - On mem_ack, capture load data: (mem_rdata >> 8*off), masked to 8/16/32 bits; err = 0 -> RESP.
  - The counter increments each BUS cycle without ack. If TIMEOUT != 0 and the counter reaches TIMEOUT, drop mem_req, set err = 1 -> RESP.
  - The counter clears on BUS entry.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata, rsp_funct3 and rsp_err.
  - rsp_rdata = 0 for stores and errors.
  - Returns to IDLE.
  - req_ready = 0; a new request is accepted no earlier than the following IDLE cycle.
- Latency:
  - Best case, valid at edge N, ack in the first BUS cycle: BUS is cycle N+1, rsp_valid in cycle N+2.
  - Error path: rsp_valid in cycle N+1.
- mem_ack outside BUS is ignored.
- req_valid while not ready is ignored; the requester holds it.
- Ack and timeout in the same cycle: ack wins.
- mem_rdata is sampled only on the ack cycle.
- Output registers are stable except in the cycle of the state transition.

Decomposition:
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum, BE base constants, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Sub-module lsu_lane_align (combinational): store side computes be and replicated wdata; load side performs shift and size mask. The FSM and counter stay in the top.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ack after 2 wait cycles -> mem_addr 0x100, be 1111, mem_wdata 0xDEADBEEF held stable 3 cycles; single rsp_valid, err 0, rsp_rdata 0.
- LB addr 0x103, mem_rdata 0x80112233, immediate ack -> be 1000, mem_addr 0x100, rsp_rdata 0x00000080, rsp_funct3 000, rsp_valid exactly 2 cycles after accept.
- SH addr 0x102, wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCDABCD; LHU addr 0x102 with rdata 0xBEEF0000 -> rsp_rdata 0x0000BEEF.
- LW addr 0x102; then SH addr 0x101; then funct3 011 -> no mem_req; rsp_valid next cycle with err 1 each time.
- TIMEOUT = 4, LW addr 0x0, ack never -> mem_req high 4 cycles then low; rsp err 1. A late ack 2 cycles later is ignored.
- Reset pulsed in BUS -> mem_req 0 and req_ready 1 immediately, no rsp_valid. A subsequent LBU addr 0x1 with rdata 0x0000FF00 returns 0x000000FF.
